// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute sequencer driving the datapath strobe interface.
// Define MULDIV_EN to execute mul/div; when it is undefined those opcodes run as nop.
module control_sequencer #(
  parameter int OPCODE_W = 5,
  parameter int NREGS    = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      ir,
  input  logic             con_ff,
  input  logic             mem_ready,
  output logic [NREGS-1:0] rin,
  output logic [NREGS-1:0] rout,
  output logic             PCin,
  output logic             PCout,
  output logic             IncPC,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             MARin,
  output logic             MDRin,
  output logic             MDRout,
  output logic             HIin,
  output logic             HIout,
  output logic             LOin,
  output logic             LOout,
  output logic             Zhighout,
  output logic             Zlowout,
  output logic             Cout,
  output logic             CONin,
  output logic [3:0]       ALUselect,
  output logic             Read,
  output logic             Write,
  output logic             run
);

  typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_LDI  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_SHL  = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_MUL  = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_DIV  = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OP_BR   = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] OP_JR   = OPCODE_W'(13);
  localparam logic [OPCODE_W-1:0] OP_MFHI = OPCODE_W'(14);
  localparam logic [OPCODE_W-1:0] OP_MFLO = OPCODE_W'(15);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(26);

  state_t               state;
  logic [31:0]          ir_reg;
  logic [OPCODE_W-1:0]  op;
  logic [3:0]           ra, rb, rc;
  logic [NREGS-1:0]     ra_oh, rb_oh, rc_oh;
  logic                 is_rtype, is_imm, is_ld, is_st, is_md, is_br;
  logic                 is_jr, is_mfhi, is_mflo, is_halt;
  logic                 unused_ir;

  assign op        = ir_reg[31 -: OPCODE_W];
  assign ra        = ir_reg[26:23];
  assign rb        = ir_reg[22:19];
  assign rc        = ir_reg[18:15];
  assign unused_ir = ^ir_reg[14:0];

  assign ra_oh = NREGS'(1) << ra;
  assign rb_oh = NREGS'(1) << rb;
  assign rc_oh = NREGS'(1) << rc;

  assign is_rtype = (op >= OP_ADD) && (op <= OP_SHL);
  assign is_imm   = (op == OP_ADDI) || (op == OP_LDI);
  assign is_ld    = (op == OP_LD);
  assign is_st    = (op == OP_ST);
  assign is_br    = (op == OP_BR);
  assign is_jr    = (op == OP_JR);
  assign is_mfhi  = (op == OP_MFHI);
  assign is_mflo  = (op == OP_MFLO);
  assign is_halt  = (op == OP_HALT);
`ifdef MULDIV_EN
  assign is_md    = (op == OP_MUL) || (op == OP_DIV);
`else
  assign is_md    = 1'b0;
`endif

  // ir is re-latched every cycle; the datapath holds IR stable from T2 on.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state  <= RST;
      ir_reg <= '0;
    end else begin
      ir_reg <= ir;
      case (state)
        RST:  state <= T0;
        T0:   state <= T1;
        T1:   state <= mem_ready ? T2 : T1;
        T2:   state <= T3;
        T3: begin
          if (is_halt)
            state <= HALT;
          else if (is_rtype || is_imm || is_ld || is_st || is_md || is_br)
            state <= T4;
          else
            state <= T0;
        end
        T4:   state <= T5;
        T5:   state <= (is_rtype || is_imm) ? T0 : T6;
        T6: begin
          if (is_ld)
            state <= mem_ready ? T7 : T6;
          else if (is_st)
            state <= T7;
          else
            state <= T0;
        end
        T7: begin
          if (is_st)
            state <= mem_ready ? T0 : T7;
          else
            state <= T0;
        end
        HALT: state <= HALT;
        default: state <= RST;
      endcase
    end
  end

  assign run = (state != RST) && (state != HALT);

  // Strobes are a pure decode of the state register and latched IR; con_ff only gates br's T6 PCin.
  always_comb begin
    rin = '0;  rout = '0;
    PCin = 1'b0;  PCout = 1'b0;  IncPC = 1'b0;  IRin = 1'b0;
    Yin = 1'b0;  Zin = 1'b0;  MARin = 1'b0;  MDRin = 1'b0;  MDRout = 1'b0;
    HIin = 1'b0;  HIout = 1'b0;  LOin = 1'b0;  LOout = 1'b0;
    Zhighout = 1'b0;  Zlowout = 1'b0;  Cout = 1'b0;  CONin = 1'b0;
    ALUselect = 4'd0;  Read = 1'b0;  Write = 1'b0;
    case (state)
      T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      T2: begin MDRout = 1'b1; IRin = 1'b1; end
      T3: begin
        if (is_rtype || is_imm || is_ld || is_st) begin
          rout = rb_oh; Yin = 1'b1;
        end else if (is_md) begin
          rout = ra_oh; Yin = 1'b1;
        end else if (is_br) begin
          rout = ra_oh; CONin = 1'b1;
        end else if (is_jr) begin
          rout = ra_oh; PCin = 1'b1;
        end else if (is_mfhi) begin
          HIout = 1'b1; rin = ra_oh;
        end else if (is_mflo) begin
          LOout = 1'b1; rin = ra_oh;
        end
      end
      T4: begin
        if (is_rtype) begin
          rout = rc_oh; ALUselect = 4'(op - OP_ADD); Zin = 1'b1;
        end else if (is_imm || is_ld || is_st) begin
          Cout = 1'b1; Zin = 1'b1;
        end else if (is_md) begin
          rout = rb_oh; ALUselect = (op == OP_DIV) ? 4'd7 : 4'd6; Zin = 1'b1;
        end else if (is_br) begin
          PCout = 1'b1; Yin = 1'b1;
        end
      end
      T5: begin
        if (is_rtype || is_imm) begin
          Zlowout = 1'b1; rin = ra_oh;
        end else if (is_ld || is_st) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else if (is_md) begin
          Zlowout = 1'b1; LOin = 1'b1;
        end else if (is_br) begin
          Cout = 1'b1; Zin = 1'b1;
        end
      end
      T6: begin
        if (is_ld) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (is_st) begin
          rout = ra_oh; MDRin = 1'b1;
        end else if (is_md) begin
          Zhighout = 1'b1; HIin = 1'b1;
        end else if (is_br) begin
          Zlowout = 1'b1; PCin = con_ff;
        end
      end
      T7: begin
        if (is_ld) begin
          MDRout = 1'b1; rin = ra_oh;
        end else if (is_st) begin
          MDRout = 1'b1; Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: expands each instruction into its expected micro-step list and checks every cycle.
module tb_control_sequencer;
  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] ir;
  logic        con_ff, mem_ready;
  logic [15:0] rin, rout;
  logic PCin, PCout, IncPC, IRin, Yin, Zin, MARin, MDRin, MDRout, HIin, HIout;
  logic LOin, LOout, Zhighout, Zlowout, Cout, CONin, Read, Write, run;
  logic [3:0]  ALUselect;

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready),
    .rin(rin), .rout(rout), .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout), .Zhighout(Zhighout),
    .Zlowout(Zlowout), .Cout(Cout), .CONin(CONin), .ALUselect(ALUselect),
    .Read(Read), .Write(Write), .run(run)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic pcin, pcout, incpc, irin, yin, zin, marin, mdrin, mdrout;
    logic hiin, hiout, loin, loout, zhighout, zlowout, cout, conin;
    logic [3:0] alu;
    logic rd, wr, run;
  } ctl_t;

  // mr: -1 drive random mem_ready, 0/1 force it
  typedef struct { ctl_t c; int mr; } ent_t;

`ifdef MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  ent_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic ctl_t obs();
    ctl_t o;
    o = {rin, rout, PCin, PCout, IncPC, IRin, Yin, Zin, MARin, MDRin, MDRout,
         HIin, HIout, LOin, LOout, Zhighout, Zlowout, Cout, CONin, ALUselect, Read, Write, run};
    return o;
  endfunction

  function automatic ctl_t base();
    ctl_t c = '0;
    c.run = 1'b1;
    return c;
  endfunction

  function automatic logic [15:0] oh(logic [3:0] r);
    logic [15:0] v = 16'd1;
    return v << r;
  endfunction

  function automatic logic [31:0] enc(int op, int ra, int rb, int rc);
    return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'($urandom)};
  endfunction

  task automatic check(string tag, ctl_t exp);
    ctl_t o = obs();
    checks++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, exp);
    end
  endtask

  task automatic push(ctl_t c, int mr);
    ent_t e;
    e.c = c; e.mr = mr;
    q.push_back(e);
  endtask

  task automatic push_wait(ctl_t c, int w);
    for (int i = 0; i < w; i++) push(c, 0);
    push(c, 1);
  endtask

  // Micro-program of one instruction, including memory wait repetitions.
  task automatic build(logic [31:0] instr, int w1, int wm, bit con);
    logic [4:0] op = instr[31:27];
    logic [3:0] ra = instr[26:23];
    logic [3:0] rb = instr[22:19];
    logic [3:0] rc = instr[18:15];
    ctl_t c;
    q.delete();
    c = base(); c.pcout = 1; c.marin = 1; c.incpc = 1; c.zin = 1; push(c, -1);
    c = base(); c.zlowout = 1; c.pcin = 1; c.rd = 1; c.mdrin = 1; push_wait(c, w1);
    c = base(); c.mdrout = 1; c.irin = 1; push(c, -1);
    if (op >= 3 && op <= 8) begin
      c = base(); c.rout = oh(rb); c.yin = 1; push(c, -1);
      c = base(); c.rout = oh(rc); c.alu = 4'(op - 3); c.zin = 1; push(c, -1);
      c = base(); c.zlowout = 1; c.rin = oh(ra); push(c, -1);
    end else if (op == 0 || op == 1 || op == 2 || op == 9) begin
      c = base(); c.rout = oh(rb); c.yin = 1; push(c, -1);
      c = base(); c.cout = 1; c.zin = 1; push(c, -1);
      c = base(); c.zlowout = 1;
      if (op == 1 || op == 9) c.rin = oh(ra); else c.marin = 1;
      push(c, -1);
      if (op == 0) begin
        c = base(); c.rd = 1; c.mdrin = 1; push_wait(c, wm);
        c = base(); c.mdrout = 1; c.rin = oh(ra); push(c, -1);
      end else if (op == 2) begin
        c = base(); c.rout = oh(ra); c.mdrin = 1; push(c, -1);
        c = base(); c.mdrout = 1; c.wr = 1; push_wait(c, wm);
      end
    end else if (MD && (op == 10 || op == 11)) begin
      c = base(); c.rout = oh(ra); c.yin = 1; push(c, -1);
      c = base(); c.rout = oh(rb); c.alu = (op == 10) ? 4'd6 : 4'd7; c.zin = 1; push(c, -1);
      c = base(); c.zlowout = 1; c.loin = 1; push(c, -1);
      c = base(); c.zhighout = 1; c.hiin = 1; push(c, -1);
    end else if (op == 12) begin
      c = base(); c.rout = oh(ra); c.conin = 1; push(c, -1);
      c = base(); c.pcout = 1; c.yin = 1; push(c, -1);
      c = base(); c.cout = 1; c.zin = 1; push(c, -1);
      c = base(); c.zlowout = 1; c.pcin = con; push(c, -1);
    end else if (op == 13) begin
      c = base(); c.rout = oh(ra); c.pcin = 1; push(c, -1);
    end else if (op == 14) begin
      c = base(); c.hiout = 1; c.rin = oh(ra); push(c, -1);
    end else if (op == 15) begin
      c = base(); c.loout = 1; c.rin = oh(ra); push(c, -1);
    end else begin
      push(base(), -1);
    end
  endtask

  // Entered and left at #1 after a rising edge; abort_idx pulls clear low during that step.
  task automatic execute(logic [31:0] instr, int w1, int wm, bit con, int abort_idx, string name);
    build(instr, w1, wm, con);
    ir = instr;
    con_ff = con;
    for (int i = 0; i < q.size(); i++) begin
      mem_ready = (q[i].mr < 0) ? 1'($urandom_range(0, 1)) : (q[i].mr != 0);
      #1;
      check($sformatf("%s/step%0d", name, i), q[i].c);
      if (i == abort_idx) begin
        clear = 1'b0;
        #1;
        check($sformatf("%s/async_reset", name), '0);
        @(posedge clock); #1;
        check($sformatf("%s/reset_hold", name), '0);
        clear = 1'b1;
        @(posedge clock); #1;
        $display("instr %-14s ir=%08h aborted at step %0d", name, instr, i);
        return;
      end
      @(posedge clock); #1;
    end
    $display("instr %-14s ir=%08h op=%0d cycles=%0d", name, instr, instr[31:27], q.size());
  endtask

  initial begin
    ctl_t t0;
    int op;
    clear = 1'b0; ir = '0; con_ff = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", '0);
    clear = 1'b1;
    @(posedge clock); #1;

    execute(enc(3, 3, 1, 2), 0, 0, 0, 4, "add_reset_t4");
    execute(enc(3, 3, 1, 2), 3, 0, 0, -1, "add_fetchwait3");
    execute(enc(3, 3, 1, 2), 0, 0, 0, -1, "add_r3_r1_r2");
    execute(enc(12, 4, 0, 0), 0, 0, 0, -1, "br_con0");
    execute(enc(12, 4, 0, 0), 0, 0, 1, -1, "br_con1");
    execute(enc(2, 5, 6, 0), 0, 2, 0, -1, "st_r5_wait2");
    execute(enc(10, 7, 8, 0), 0, 0, 0, -1, "mul");
    execute(enc(11, 9, 10, 0), 1, 0, 0, -1, "div");
    execute(enc(0, 11, 12, 0), 0, 1, 0, -1, "ld_wait1");
    execute(enc(1, 15, 0, 0), 0, 0, 0, -1, "ldi");
    execute(enc(9, 2, 14, 0), 0, 0, 0, -1, "addi");
    execute(enc(8, 0, 15, 13), 0, 0, 0, -1, "shl");
    execute(enc(13, 6, 0, 0), 0, 0, 0, -1, "jr");
    execute(enc(14, 1, 0, 0), 0, 0, 0, -1, "mfhi");
    execute(enc(15, 14, 0, 0), 0, 0, 0, -1, "mflo");
    execute(enc(25, 0, 0, 0), 0, 0, 0, -1, "nop");
    execute(enc(31, 3, 3, 3), 0, 0, 0, -1, "illegal");

    for (int n = 0; n < 40; n++) begin
      do op = $urandom_range(0, 31); while (op == 26);
      execute(enc(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)),
              $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1,
              $sformatf("rand%0d", n));
    end

    execute(enc(26, 0, 0, 0), 1, 0, 0, -1, "halt");
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("halted%0d", i), '0);
      @(posedge clock); #1;
    end
    clear = 1'b0;
    @(posedge clock); #1;
    check("halt_reset", '0);
    clear = 1'b1;
    @(posedge clock); #1;
    t0 = base(); t0.pcout = 1; t0.marin = 1; t0.incpc = 1; t0.zin = 1;
    check("post_halt_t0", t0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
